// File: rtl/hazard_sequencer_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_sequencer_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam int unsigned MAX_BUBBLES = 3;
  typedef logic [1:0] bubble_cnt_t;

  typedef logic [1:0] hazard_state_e;
  localparam hazard_state_e RUN        = 2'd0;
  localparam hazard_state_e MEM_WAIT   = 2'd1;
  localparam hazard_state_e LOAD_STALL = 2'd2;
  localparam hazard_state_e REDIRECT   = 2'd3;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard-sequencer control bus: pipeline status in, stage controls out.
interface hazard_sequencer_if
  import hazard_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
);
  reg_addr_t              i_id_rs1;
  reg_addr_t              i_id_rs2;
  logic                   i_id_use_rs1;
  logic                   i_id_use_rs2;
  reg_addr_t              i_ex_reg_destination;
  logic                   i_ex_reg_wr;
  logic                   i_ex_mem_rd;
  logic                   i_ex_redirect;
  logic                   i_dmem_req;
  logic                   i_dmem_ready;
  logic                   o_if_stall;
  logic                   o_if_flush;
  logic                   o_id_clk_en;
  logic                   o_id_flush;
  logic                   o_id_insert_nop;
  logic [CNT_WIDTH-1:0]   o_stall_cycles;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_ex_reg_destination,
           i_ex_reg_wr, i_ex_mem_rd, i_ex_redirect, i_dmem_req, i_dmem_ready,
    input  o_if_stall, o_if_flush, o_id_clk_en, o_id_flush, o_id_insert_nop, o_stall_cycles
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_ex_reg_destination,
           i_ex_reg_wr, i_ex_mem_rd, i_ex_redirect, i_dmem_req, i_dmem_ready,
    output o_if_stall, o_if_flush, o_id_clk_en, o_id_flush, o_id_insert_nop, o_stall_cycles
  );
endinterface

// File: rtl/hazard_sequencer_detect.sv
// Combinational load-use hazard compare between the EX load and the ID operands.
module hazard_detect
  import hazard_sequencer_pkg::*;
(
  input  reg_addr_t id_rs1_i,
  input  reg_addr_t id_rs2_i,
  input  logic      id_use_rs1_i,
  input  logic      id_use_rs2_i,
  input  reg_addr_t ex_rd_i,
  input  logic      ex_reg_wr_i,
  input  logic      ex_mem_rd_i,
  output logic      load_use_o
);
  logic rs1_hit, rs2_hit;

  always_comb begin
    rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    // x0 is hardwired zero, so a load targeting it never produces a value to wait on
    load_use_o = ex_mem_rd_i && ex_reg_wr_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
  end
endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline control FSM: freezes on memory waits, flushes on redirects and
// inserts bubbles on load-use hazards; counts IF stall cycles.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned CNT_WIDTH        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_sequencer_if.slave bus
);
  hazard_state_e        state_q, state_d;
  bubble_cnt_t          bub_q, bub_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic load_use, mem_stall;
  logic if_stall, if_flush, id_clk_en, id_flush, id_nop;

  hazard_detect u_detect (
    .id_rs1_i     (bus.i_id_rs1),
    .id_rs2_i     (bus.i_id_rs2),
    .id_use_rs1_i (bus.i_id_use_rs1),
    .id_use_rs2_i (bus.i_id_use_rs2),
    .ex_rd_i      (bus.i_ex_reg_destination),
    .ex_reg_wr_i  (bus.i_ex_reg_wr),
    .ex_mem_rd_i  (bus.i_ex_mem_rd),
    .load_use_o   (load_use)
  );

  assign mem_stall = bus.i_dmem_req && !bus.i_dmem_ready;

  always_comb begin
    state_d   = state_q;
    bub_d     = bub_q;
    if_stall  = 1'b0;
    if_flush  = 1'b0;
    id_clk_en = 1'b1;
    id_flush  = 1'b0;
    id_nop    = 1'b0;
    if (state_q == MEM_WAIT || mem_stall) begin
      // Full freeze; pending redirect/load-use inputs are held and re-seen afterwards
      if_stall  = 1'b1;
      id_clk_en = 1'b0;
      if (state_q == MEM_WAIT) begin
        if (bus.i_dmem_ready) state_d = RUN;
      end else if (state_q == RUN) begin
        state_d = MEM_WAIT;
      end
    end else if (bus.i_ex_redirect) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      id_nop   = 1'b1;
      if (REDIRECT_BUBBLES > 0) begin
        state_d = REDIRECT;
        bub_d   = bubble_cnt_t'(REDIRECT_BUBBLES);
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      if (load_use) begin
        if_stall = 1'b1;
        id_flush = 1'b1;
        if (LOAD_USE_BUBBLES > 1) begin
          state_d = LOAD_STALL;
          bub_d   = bubble_cnt_t'(LOAD_USE_BUBBLES - 1);
        end
      end
    end else begin
      // LOAD_STALL or REDIRECT bubble cycle
      id_flush = 1'b1;
      if (state_q == LOAD_STALL) if_stall = 1'b1;
      else                       id_nop   = 1'b1;
      if (bub_q == bubble_cnt_t'(1)) state_d = RUN;
      else                           bub_d   = bub_q - bubble_cnt_t'(1);
    end

    stall_cnt_d = stall_cnt_q;
    if (if_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);

    if (!rst_n) begin
      if_stall  = 1'b0;
      if_flush  = 1'b1;
      id_clk_en = 1'b1;
      id_flush  = 1'b1;
      id_nop    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      bub_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bub_q       <= bub_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_if_stall      = if_stall;
  assign bus.o_if_flush      = if_flush;
  assign bus.o_id_clk_en     = id_clk_en;
  assign bus.o_id_flush      = id_flush;
  assign bus.o_id_insert_nop = id_nop;
  assign bus.o_stall_cycles  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench: dut_a uses default parameters, dut_b uses 3 load-use bubbles
// and a 3-bit stall counter; both see the same inputs.
module tb_hazard_sequencer;
  import hazard_sequencer_pkg::*;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, ld, redir, req, rdy;
  } in_t;

  typedef struct {
    int          sel;
    logic        stall, iflush, clken, idflush, nop;
    logic        chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_sequencer_if #(.CNT_WIDTH(32)) ifa ();
  hazard_sequencer_if #(.CNT_WIDTH(3))  ifb ();

  hazard_sequencer #(.LOAD_USE_BUBBLES(1), .REDIRECT_BUBBLES(1), .CNT_WIDTH(32)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );
  hazard_sequencer #(.LOAD_USE_BUBBLES(3), .REDIRECT_BUBBLES(1), .CNT_WIDTH(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  in_t  cur;
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  assign ifa.i_id_rs1 = cur.rs1;             assign ifb.i_id_rs1 = cur.rs1;
  assign ifa.i_id_rs2 = cur.rs2;             assign ifb.i_id_rs2 = cur.rs2;
  assign ifa.i_id_use_rs1 = cur.u1;          assign ifb.i_id_use_rs1 = cur.u1;
  assign ifa.i_id_use_rs2 = cur.u2;          assign ifb.i_id_use_rs2 = cur.u2;
  assign ifa.i_ex_reg_destination = cur.rd;  assign ifb.i_ex_reg_destination = cur.rd;
  assign ifa.i_ex_reg_wr = cur.wr;           assign ifb.i_ex_reg_wr = cur.wr;
  assign ifa.i_ex_mem_rd = cur.ld;           assign ifb.i_ex_mem_rd = cur.ld;
  assign ifa.i_ex_redirect = cur.redir;      assign ifb.i_ex_redirect = cur.redir;
  assign ifa.i_dmem_req = cur.req;           assign ifb.i_dmem_req = cur.req;
  assign ifa.i_dmem_ready = cur.rdy;         assign ifb.i_dmem_ready = cur.rdy;
  assign rst_n = cur.rst_n;

  function automatic in_t mi(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                             logic [4:0] rd, logic wr, logic ld, logic redir, logic req,
                             logic rdy);
    in_t v;
    v.rst_n = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.wr = wr; v.ld = ld; v.redir = redir; v.req = req; v.rdy = rdy;
    return v;
  endfunction

  function automatic exp_t me(int sel, logic st, logic ifl, logic ce, logic idf, logic nop,
                              logic chk, logic [31:0] cnt);
    exp_t e;
    e.sel = sel; e.stall = st; e.iflush = ifl; e.clken = ce; e.idflush = idf; e.nop = nop;
    e.chk_cnt = chk; e.cnt = cnt;
    return e;
  endfunction

  task automatic cyc(input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    cur = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare the selected DUT.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.sel == 0) begin
        chk("a.if_stall", 32'(ifa.o_if_stall), 32'(e.stall));
        chk("a.if_flush", 32'(ifa.o_if_flush), 32'(e.iflush));
        chk("a.id_clk_en", 32'(ifa.o_id_clk_en), 32'(e.clken));
        chk("a.id_flush", 32'(ifa.o_id_flush), 32'(e.idflush));
        chk("a.insert_nop", 32'(ifa.o_id_insert_nop), 32'(e.nop));
        if (e.chk_cnt) chk("a.stall_cycles", ifa.o_stall_cycles, e.cnt);
      end else begin
        chk("b.if_stall", 32'(ifb.o_if_stall), 32'(e.stall));
        chk("b.if_flush", 32'(ifb.o_if_flush), 32'(e.iflush));
        chk("b.id_clk_en", 32'(ifb.o_id_clk_en), 32'(e.clken));
        chk("b.id_flush", 32'(ifb.o_id_flush), 32'(e.idflush));
        chk("b.insert_nop", 32'(ifb.o_id_insert_nop), 32'(e.nop));
        if (e.chk_cnt) chk("b.stall_cycles", 32'(ifb.o_stall_cycles), e.cnt);
      end
    end
  end

  in_t idle, rstv, lu1, lu2, ld0, redlu, mw, mwr, mwdone, red;

  initial begin
    idle   = mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstv   = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu1    = mi(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    lu2    = mi(1, 5, 5, 0, 1, 5, 1, 1, 0, 0, 0);
    ld0    = mi(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    redlu  = mi(1, 5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
    red    = mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    mw     = mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    mwr    = mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    mwdone = mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cur    = rstv;

    // dut_a: default parameters
    cyc(rstv,   me(0, 0, 1, 1, 1, 1, 0, 0));
    cyc(idle,   me(0, 0, 0, 1, 0, 0, 1, 0));
    cyc(lu1,    me(0, 1, 0, 1, 1, 0, 1, 0));
    cyc(idle,   me(0, 0, 0, 1, 0, 0, 1, 1));
    cyc(ld0,    me(0, 0, 0, 1, 0, 0, 1, 1));
    cyc(lu2,    me(0, 1, 0, 1, 1, 0, 1, 1));
    cyc(idle,   me(0, 0, 0, 1, 0, 0, 1, 2));
    cyc(redlu,  me(0, 0, 1, 1, 1, 1, 1, 2));
    cyc(idle,   me(0, 0, 0, 1, 1, 1, 1, 2));
    cyc(idle,   me(0, 0, 0, 1, 0, 0, 1, 2));
    cyc(mw,     me(0, 1, 0, 0, 0, 0, 1, 2));
    cyc(mwr,    me(0, 1, 0, 0, 0, 0, 1, 3));
    cyc(mw,     me(0, 1, 0, 0, 0, 0, 1, 4));
    cyc(mwr,    me(0, 1, 0, 0, 0, 0, 1, 5));
    cyc(mwdone, me(0, 1, 0, 0, 0, 0, 1, 6));
    cyc(idle,   me(0, 0, 0, 1, 0, 0, 1, 7));

    // dut_b: 3 load-use bubbles, redirect abandons the stall in its 2nd bubble
    cyc(rstv,   me(1, 0, 1, 1, 1, 1, 0, 0));
    cyc(idle,   me(1, 0, 0, 1, 0, 0, 1, 0));
    cyc(lu1,    me(1, 1, 0, 1, 1, 0, 1, 0));
    cyc(red,    me(1, 0, 1, 1, 1, 1, 1, 1));
    cyc(idle,   me(1, 0, 0, 1, 1, 1, 1, 1));
    cyc(idle,   me(1, 0, 0, 1, 0, 0, 1, 1));
    // uninterrupted 3-bubble stall
    cyc(lu1,    me(1, 1, 0, 1, 1, 0, 1, 1));
    cyc(idle,   me(1, 1, 0, 1, 1, 0, 1, 2));
    cyc(idle,   me(1, 1, 0, 1, 1, 0, 1, 3));
    cyc(idle,   me(1, 0, 0, 1, 0, 0, 1, 4));
    // reset in the middle of LOAD_STALL
    cyc(lu1,    me(1, 1, 0, 1, 1, 0, 1, 4));
    cyc(rstv,   me(1, 0, 1, 1, 1, 1, 1, 5));
    cyc(idle,   me(1, 0, 0, 1, 0, 0, 1, 0));
    // 3-bit counter saturates at 7
    for (int i = 0; i < 8; i++) cyc(mw, me(1, 1, 0, 0, 0, 0, 1, 32'(i)));
    cyc(mwdone, me(1, 1, 0, 0, 0, 0, 1, 7));
    cyc(idle,   me(1, 0, 0, 1, 0, 0, 1, 7));
    // memory stall inside LOAD_STALL holds the bubble counter
    cyc(lu1,    me(1, 1, 0, 1, 1, 0, 1, 7));
    cyc(mw,     me(1, 1, 0, 0, 0, 0, 1, 7));
    cyc(idle,   me(1, 1, 0, 1, 1, 0, 1, 7));
    cyc(idle,   me(1, 1, 0, 1, 1, 0, 1, 7));
    cyc(idle,   me(1, 0, 0, 1, 0, 0, 1, 7));

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
